// File: rtl/flood_engine.sv
// flood_engine: Flood-It game-state controller. Holds the board, fills it from
// a Galois LFSR on START, and runs each move as repeated raster flood sweeps
// from cell (0,0) until a pass claims no new cells.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | after reset, waiting for START
// ST_GEN   | writing one pseudo-random colour per cycle, raster order
// ST_SWEEP | one flood pass per S*S cycles; repeats while cells are claimed
// ST_EVAL  | one cycle: win / lose / continue decision
// ST_PLAY  | waiting for a move handshake
// ST_OVER  | game finished, board and status frozen until START
module flood_engine #(
  parameter int MAX_DIM    = 26,
  parameter int NUM_COLORS = 6,
  parameter int MOVE_LIMIT = 25
) (
  input  logic        CLOCK,
  input  logic        RESET_N,
  input  logic        START,
  input  logic [4:0]  SIZE_IN,
  input  logic [15:0] SEED,
  input  logic        MOVE_VALID,
  input  logic [2:0]  MOVE_COLOR,
  output logic        MOVE_READY,
  input  logic [4:0]  RD_ROW,
  input  logic [4:0]  RD_COL,
  output logic [2:0]  RD_COLOR,
  output logic [4:0]  FINAL_SIZE,
  output logic        INIT_DONE,
  output logic [5:0]  MOVES,
  output logic        BUSY,
  output logic        GAME_WIN,
  output logic        GAME_LOSE
);

  localparam logic [4:0] MAX_SZ   = 5'(MAX_DIM);
  localparam logic [2:0] NUM_COL  = 3'(NUM_COLORS);
  localparam logic [5:0] MOVE_LIM = 6'(MOVE_LIMIT);

  typedef enum logic [2:0] {
    ST_IDLE, ST_GEN, ST_SWEEP, ST_EVAL, ST_PLAY, ST_OVER
  } state_t;

  state_t      state, state_nxt;
  logic [2:0]  color_mem [MAX_DIM][MAX_DIM];
  logic        own_mem   [MAX_DIM][MAX_DIM];
  logic [4:0]  size_q;
  logic [15:0] lfsr;
  logic [2:0]  flood_color;
  logic [9:0]  own_count;
  logic [4:0]  row, col;
  logic        changed;
  logic [5:0]  moves;
  logic        win, lose, init_done;

  logic [4:0]  size_clamped;
  logic [15:0] lfsr_step;
  logic [2:0]  gen_color;
  logic        last_cell;
  logic [4:0]  row_n, row_s, col_w, col_e;
  logic        nb_own, sweep_join, move_ok;
  logic [9:0]  area;

  assign size_clamped = (SIZE_IN < 5'd2) ? 5'd2 : ((SIZE_IN > MAX_SZ) ? MAX_SZ : SIZE_IN);
  assign lfsr_step    = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  assign gen_color    = (lfsr_step[2:0] >= NUM_COL) ? (lfsr_step[2:0] - NUM_COL) : lfsr_step[2:0];
  assign last_cell    = (row == size_q - 5'd1) && (col == size_q - 5'd1);
  assign row_n        = row - 5'd1;
  assign row_s        = row + 5'd1;
  assign col_w        = col - 5'd1;
  assign col_e        = col + 5'd1;
  // neighbour ownership is read in place, so cells claimed earlier in this pass count
  assign nb_own       = ((row != 5'd0) && own_mem[row_n][col]) ||
                        ((row_s < size_q) && own_mem[row_s][col]) ||
                        ((col != 5'd0) && own_mem[row][col_w]) ||
                        ((col_e < size_q) && own_mem[row][col_e]);
  assign sweep_join   = !own_mem[row][col] && (color_mem[row][col] == flood_color) && nb_own;
  assign move_ok      = (MOVE_COLOR < NUM_COL) && (MOVE_COLOR != flood_color);
  assign area         = {5'd0, size_q} * {5'd0, size_q};

  assign RD_COLOR   = ((RD_ROW < size_q) && (RD_COL < size_q)) ? color_mem[RD_ROW][RD_COL] : 3'd0;
  assign FINAL_SIZE = size_q;
  assign INIT_DONE  = init_done;
  assign MOVES      = moves;
  assign GAME_WIN   = win;
  assign GAME_LOSE  = lose;

  // state register
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // next-state and status outputs; START overrides every state
  always_comb begin
    state_nxt  = state;
    BUSY       = (state == ST_GEN) || (state == ST_SWEEP);
    MOVE_READY = (state == ST_PLAY);
    if (START) begin
      state_nxt = ST_GEN;
    end else begin
      case (state)
        ST_GEN:   if (last_cell) state_nxt = ST_SWEEP;
        // a claim on the final cell can still unlock earlier cells, so it forces another pass
        ST_SWEEP: if (last_cell && !(changed || sweep_join)) state_nxt = ST_EVAL;
        ST_EVAL: begin
          if (own_count == area)   state_nxt = ST_OVER;
          else if (moves >= MOVE_LIM) state_nxt = ST_OVER;
          else                     state_nxt = ST_PLAY;
        end
        ST_PLAY:  if (MOVE_VALID && move_ok) state_nxt = ST_SWEEP;
        default:  state_nxt = state;
      endcase
    end
  end

  // game datapath: size, LFSR, scan pointer, flood colour, counters, status
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      size_q      <= 5'd0;
      lfsr        <= 16'hACE1;
      flood_color <= 3'd0;
      own_count   <= 10'd0;
      row         <= 5'd0;
      col         <= 5'd0;
      changed     <= 1'b0;
      moves       <= 6'd0;
      win         <= 1'b0;
      lose        <= 1'b0;
      init_done   <= 1'b0;
    end else if (START) begin
      size_q    <= size_clamped;
      lfsr      <= (SEED == 16'd0) ? 16'hACE1 : SEED;
      row       <= 5'd0;
      col       <= 5'd0;
      changed   <= 1'b0;
      moves     <= 6'd0;
      win       <= 1'b0;
      lose      <= 1'b0;
      init_done <= 1'b0;
    end else begin
      if ((state == ST_GEN) || (state == ST_SWEEP)) begin
        if (last_cell) begin
          row <= 5'd0;
          col <= 5'd0;
        end else if (col == size_q - 5'd1) begin
          row <= row + 5'd1;
          col <= 5'd0;
        end else begin
          col <= col + 5'd1;
        end
      end
      case (state)
        ST_GEN: begin
          lfsr <= lfsr_step;
          if (last_cell) begin
            own_count   <= 10'd1;
            flood_color <= color_mem[0][0];
            changed     <= 1'b0;
          end
        end
        ST_SWEEP: begin
          if (sweep_join) own_count <= own_count + 10'd1;
          if (last_cell)       changed <= 1'b0;
          else if (sweep_join) changed <= 1'b1;
        end
        ST_EVAL: begin
          if (own_count == area)      win       <= 1'b1;
          else if (moves >= MOVE_LIM) lose      <= 1'b1;
          else                        init_done <= 1'b1;
        end
        ST_PLAY: begin
          if (MOVE_VALID && move_ok) begin
            flood_color <= MOVE_COLOR;
            moves       <= (moves == 6'd63) ? moves : moves + 6'd1;
            changed     <= 1'b0;
            row         <= 5'd0;
            col         <= 5'd0;
          end
        end
        default: ;
      endcase
    end
  end

  // ownership map: wiped on START, seeded at (0,0) after GEN, grown by sweeps
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < MAX_DIM; i++)
        for (int j = 0; j < MAX_DIM; j++)
          own_mem[i][j] <= 1'b0;
    end else if (START) begin
      for (int i = 0; i < MAX_DIM; i++)
        for (int j = 0; j < MAX_DIM; j++)
          own_mem[i][j] <= 1'b0;
    end else if ((state == ST_GEN) && last_cell) begin
      own_mem[0][0] <= 1'b1;
    end else if ((state == ST_SWEEP) && sweep_join) begin
      own_mem[row][col] <= 1'b1;
    end
  end

  // colour board: random fill during GEN, owned cells repainted during SWEEP
  always_ff @(posedge CLOCK) begin
    if (!START) begin
      if (state == ST_GEN)
        color_mem[row][col] <= gen_color;
      else if ((state == ST_SWEEP) && own_mem[row][col])
        color_mem[row][col] <= flood_color;
    end
  end

endmodule

// File: tb/tb_flood_engine.sv
// Scoreboard bench for flood_engine. Stimulus pushes the expected settled
// status (and for 2x2 boards the hand-derived colours) before each START or
// move; the monitor pops one entry whenever the main instance settles
// (MOVE_READY, GAME_WIN or GAME_LOSE rises). A second instance with
// MOVE_LIMIT=1 shares the inputs for the lose and win-priority cases.
module tb_flood_engine;
  logic        CLOCK = 1'b0;
  logic        RESET_N, START, MOVE_VALID;
  logic [4:0]  SIZE_IN, RD_ROW, RD_COL;
  logic [15:0] SEED;
  logic [2:0]  MOVE_COLOR;

  logic        move_ready, init_done, busy, game_win, game_lose;
  logic [2:0]  rd_color;
  logic [4:0]  final_size;
  logic [5:0]  moves;
  logic        l_move_ready, l_init_done, l_busy, l_game_win, l_game_lose;
  logic [2:0]  l_rd_color;
  logic [4:0]  l_final_size;
  logic [5:0]  l_moves;

  flood_engine dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .START(START), .SIZE_IN(SIZE_IN), .SEED(SEED),
    .MOVE_VALID(MOVE_VALID), .MOVE_COLOR(MOVE_COLOR), .MOVE_READY(move_ready),
    .RD_ROW(RD_ROW), .RD_COL(RD_COL), .RD_COLOR(rd_color), .FINAL_SIZE(final_size),
    .INIT_DONE(init_done), .MOVES(moves), .BUSY(busy), .GAME_WIN(game_win),
    .GAME_LOSE(game_lose));

  flood_engine #(.MOVE_LIMIT(1)) dut_lim (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .START(START), .SIZE_IN(SIZE_IN), .SEED(SEED),
    .MOVE_VALID(MOVE_VALID), .MOVE_COLOR(MOVE_COLOR), .MOVE_READY(l_move_ready),
    .RD_ROW(RD_ROW), .RD_COL(RD_COL), .RD_COLOR(l_rd_color), .FINAL_SIZE(l_final_size),
    .INIT_DONE(l_init_done), .MOVES(l_moves), .BUSY(l_busy), .GAME_WIN(l_game_win),
    .GAME_LOSE(l_game_lose));

  always #5 CLOCK = ~CLOCK;

  int cyc = 0;
  always @(posedge CLOCK) cyc <= cyc + 1;

  typedef struct packed {
    int         id;
    bit         chk_lat;
    int         lat;
    bit         ready;
    bit         win;
    bit         lose;
    logic [5:0] mv;
    logic [4:0] size;
    bit         chk_board;
    logic [11:0] board;   // {(0,0),(0,1),(1,0),(1,1)}
  } exp_t;

  exp_t sb[$];
  int n_vec = 0, n_bad = 0, n_ev = 0, t_mark = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int id, input bit chk_lat, input int lat, input bit ready,
                      input bit win, input bit lose, input int mv, input int size,
                      input bit chk_board, input logic [11:0] board);
    exp_t e;
    e.id = id; e.chk_lat = chk_lat; e.lat = lat; e.ready = ready; e.win = win;
    e.lose = lose; e.mv = 6'(mv); e.size = 5'(size); e.chk_board = chk_board;
    e.board = board;
    sb.push_back(e);
  endtask

  // START is sampled on the posedge following this negedge
  task automatic do_start(input int size, input logic [15:0] seed);
    @(negedge CLOCK);
    SIZE_IN = 5'(size); SEED = seed; START = 1'b1; t_mark = cyc + 1;
    @(negedge CLOCK);
    START = 1'b0;
  endtask

  task automatic do_move(input logic [2:0] color);
    @(negedge CLOCK);
    MOVE_VALID = 1'b1; MOVE_COLOR = color; t_mark = cyc + 1;
    @(negedge CLOCK);
    MOVE_VALID = 1'b0;
  endtask

  task automatic wait_ev(input int target, input int budget);
    int n = 0;
    while (n_ev < target && n < budget) begin
      @(negedge CLOCK);
      n++;
    end
    if (n_ev < target) begin
      n_vec++; n_bad++;
      $display("FAIL timeout_ev%0d: got %0d settle events, expected %0d", target, n_ev, target);
    end
  endtask

  // monitor: pop one expectation per settle event of the main instance
  initial begin : monitor
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge CLOCK);
      if (RESET_N && (move_ready | game_win | game_lose) && !prev) begin
        if (sb.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL unexpected_event: got settle at cycle %0d, expected none", cyc);
        end else begin
          e = sb.pop_front();
          check($sformatf("ev%0d_ready", e.id), int'(move_ready), int'(e.ready));
          check($sformatf("ev%0d_win", e.id), int'(game_win), int'(e.win));
          check($sformatf("ev%0d_lose", e.id), int'(game_lose), int'(e.lose));
          check($sformatf("ev%0d_moves", e.id), int'(moves), int'(e.mv));
          check($sformatf("ev%0d_size", e.id), int'(final_size), int'(e.size));
          if (e.chk_lat)
            check($sformatf("ev%0d_latency", e.id), cyc - t_mark, e.lat);
          if (e.chk_board) begin
            for (int i = 0; i < 4; i++) begin
              RD_ROW = 5'(i / 2); RD_COL = 5'(i % 2);
              #1;
              check($sformatf("ev%0d_cell%0d", e.id, i), int'(rd_color),
                    int'(e.board[11 - 3*i -: 3]));
            end
          end
        end
        n_ev++;
      end
      prev = move_ready | game_win | game_lose;
    end
  end

  initial begin : stimulus
    int bad_cells;
    bit busy_seen;
    RESET_N = 1'b0; START = 1'b0; SIZE_IN = 5'd0; SEED = 16'd0;
    MOVE_VALID = 1'b0; MOVE_COLOR = 3'd0; RD_ROW = 5'd0; RD_COL = 5'd0;

    // reset values
    #3;
    check("rst_ready", int'(move_ready), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_init", int'(init_done), 0);
    check("rst_win_lose", int'({game_win, game_lose}), 0);
    check("rst_moves", int'(moves), 0);
    check("rst_size", int'(final_size), 0);
    check("rst_rdcolor", int'(rd_color), 0);
    #20;
    @(negedge CLOCK) RESET_N = 1'b1;
    repeat (3) @(negedge CLOCK);
    check("idle_busy", int'(busy), 0);
    check("idle_ready", int'(move_ready), 0);

    // SIZE_IN=30 clamps to 26; random board must use legal colours only
    push(1, 0, 0, 1, 0, 0, 0, 26, 0, 12'h000);
    do_start(30, 16'h1234);
    check("big_size", int'(final_size), 26);
    check("big_busy", int'(busy), 1);
    wait_ev(1, 5000);
    bad_cells = 0;
    for (int r = 0; r < 26; r++)
      for (int c = 0; c < 26; c++) begin
        RD_ROW = 5'(r); RD_COL = 5'(c);
        #1;
        if (rd_color >= 3'd6) bad_cells++;
      end
    check("big_illegal_cells", bad_cells, 0);
    RD_ROW = 5'd26; RD_COL = 5'd0; #1;
    check("big_row26_read", int'(rd_color), 0);
    RD_ROW = 5'd0; RD_COL = 5'd26; #1;
    check("big_col26_read", int'(rd_color), 0);
    RD_ROW = 5'd0; RD_COL = 5'd0;

    // asynchronous reset mid-game, between clock edges
    @(negedge CLOCK);
    #2 RESET_N = 1'b0;
    #1;
    check("midrst_ready", int'(move_ready), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_init", int'(init_done), 0);
    check("midrst_size", int'(final_size), 0);
    check("midrst_rdcolor", int'(rd_color), 0);
    @(negedge CLOCK) RESET_N = 1'b1;
    repeat (2) @(negedge CLOCK);
    check("midrst_idle_busy", int'(busy), 0);

    // SIZE_IN=1 clamps to 2; seed 0 uses ACE1 -> board 0,0,4,0, two passes
    push(2, 1, 13, 1, 0, 0, 0, 2, 1, {3'd0, 3'd0, 3'd4, 3'd0});
    do_start(1, 16'h0000);
    check("small_size", int'(final_size), 2);
    check("small_busy", int'(busy), 1);
    wait_ev(2, 200);
    RD_ROW = 5'd2; RD_COL = 5'd0; #1;
    check("small_row2_read", int'(rd_color), 0);
    RD_ROW = 5'd0; RD_COL = 5'd2; #1;
    check("small_col2_read", int'(rd_color), 0);
    RD_ROW = 5'd0; RD_COL = 5'd0;

    // same colour as (0,0), then illegal 7: both consumed without effect
    busy_seen = 1'b0;
    @(negedge CLOCK) begin MOVE_VALID = 1'b1; MOVE_COLOR = 3'd0; end
    @(negedge CLOCK) begin busy_seen |= busy; MOVE_COLOR = 3'd7; end
    @(negedge CLOCK) begin busy_seen |= busy; MOVE_VALID = 1'b0; end
    repeat (2) @(negedge CLOCK) busy_seen |= busy;
    check("ignored_busy", int'(busy_seen), 0);
    check("ignored_moves", int'(moves), 0);
    check("ignored_ready", int'(move_ready), 1);

    // colour 4 claims the last cell: win with one move; limit-1 instance also wins
    push(3, 1, 9, 0, 1, 0, 1, 2, 1, {3'd4, 3'd4, 3'd4, 3'd4});
    do_move(3'd4);
    check("move4_busy", int'(busy), 1);
    check("move4_ready", int'(move_ready), 0);
    wait_ev(3, 200);
    check("lim_win_priority_win", int'(l_game_win), 1);
    check("lim_win_priority_lose", int'(l_game_lose), 0);

    // seed 7 -> board 3,1,0,0 (single pass); move 0 then move 1 wins
    push(4, 1, 9, 1, 0, 0, 0, 2, 1, {3'd3, 3'd1, 3'd0, 3'd0});
    do_start(2, 16'h0007);
    wait_ev(4, 200);
    push(5, 1, 9, 1, 0, 0, 1, 2, 1, {3'd0, 3'd1, 3'd0, 3'd0});
    do_move(3'd0);
    wait_ev(5, 200);
    check("lim_lose", int'(l_game_lose), 1);
    check("lim_lose_win", int'(l_game_win), 0);
    check("lim_lose_ready", int'(l_move_ready), 0);
    check("lim_lose_moves", int'(l_moves), 1);
    check("lim_lose_size", int'(l_final_size), 2);
    repeat (5) @(negedge CLOCK);
    check("lim_over_hold_ready", int'(l_move_ready), 0);
    check("lim_over_hold_busy", int'(l_busy), 0);
    check("lim_over_init", int'(l_init_done), 1);
    check("lim_over_cell00", int'(l_rd_color), 0);
    push(6, 1, 9, 0, 1, 0, 2, 2, 1, {3'd1, 3'd1, 3'd1, 3'd1});
    do_move(3'd1);
    wait_ev(6, 200);

    // START during the second sweep pass: clean restart, no stale ownership
    push(7, 1, 9, 1, 0, 0, 0, 2, 1, {3'd3, 3'd1, 3'd0, 3'd0});
    do_start(2, 16'h0007);
    wait_ev(7, 200);
    do_move(3'd0);
    repeat (4) @(negedge CLOCK);
    push(8, 1, 9, 1, 0, 0, 0, 2, 1, {3'd3, 3'd1, 3'd0, 3'd0});
    do_start(2, 16'h0007);
    check("abort_init", int'(init_done), 0);
    check("abort_moves", int'(moves), 0);
    check("abort_busy", int'(busy), 1);
    wait_ev(8, 200);

    // seed 1 -> uniform board: wins before any move, two passes
    push(9, 1, 13, 0, 1, 0, 0, 2, 1, {3'd0, 3'd0, 3'd0, 3'd0});
    do_start(2, 16'h0001);
    wait_ev(9, 200);

    repeat (3) @(negedge CLOCK);
    check("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
